// File: rtl/memory_read_scan.sv
// ============================================================================
// Module   : memory_read_scan
// Brief    : Single-point reads and a ready/valid full-board scan over a 16x16
//            board of 2-bit points, with an occupied-point counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module memory_read_scan (
  input  logic         clock,
  input  logic         reset,
  input  logic [511:0] board,
  input  logic         rd_req,
  input  logic [7:0]   rd_addr,
  output logic         rd_valid,
  output logic [1:0]   rd_data,
  input  logic         scan_start,
  input  logic         scan_abort,
  output logic         scan_valid,
  input  logic         scan_ready,
  output logic [7:0]   scan_addr,
  output logic [1:0]   scan_data,
  output logic         scan_done,
  output logic [8:0]   occupied_count,
  output logic         busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] SCAN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [7:0] LAST_ADDR = 8'hFF;

  logic [1:0] state;
  logic [1:0] next_state;
  logic       start_read;
  logic       start_scan;
  logic       transfer;
  logic       last_beat;
  logic [7:0] next_addr;

  // Point (x,y) lives at bit 32x+2y, which is simply twice the packed {x,y} address.
  function automatic logic [1:0] point_at(input logic [511:0] b, input logic [7:0] a);
    return b[{a, 1'b0} +: 2];
  endfunction

  assign start_read = (state == IDLE) && rd_req;
  assign start_scan = (state == IDLE) && !rd_req && scan_start;
  assign transfer   = (state == SCAN) && scan_ready;
  assign last_beat  = (scan_addr == LAST_ADDR);
  assign next_addr  = scan_addr + 8'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (rd_req) begin
          next_state = READ;
        end else if (scan_start) begin
          next_state = SCAN;
        end
      end
      READ: next_state = IDLE;
      SCAN: begin
        if (scan_abort) begin
          next_state = IDLE;
        end else if (scan_ready && last_beat) begin
          next_state = DONE;
        end
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes decode from the registered state only, keeping board off every output path.
  always_comb begin
    rd_valid   = 1'b0;
    scan_valid = 1'b0;
    scan_done  = 1'b0;
    busy       = 1'b0;
    case (state)
      READ: rd_valid = 1'b1;
      SCAN: begin
        scan_valid = 1'b1;
        busy       = 1'b1;
      end
      DONE: begin
        scan_done = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data <= 2'b00;
    end else if (start_read) begin
      rd_data <= point_at(board, rd_addr);
    end
  end

  // Beat registers only move on a transfer, so a stalled beat ignores board changes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_addr      <= 8'h00;
      scan_data      <= 2'b00;
      occupied_count <= 9'd0;
    end else if (start_scan) begin
      scan_addr      <= 8'h00;
      scan_data      <= point_at(board, 8'h00);
      occupied_count <= 9'd0;
    end else if (transfer) begin
      if (scan_data != 2'b00) begin
        occupied_count <= occupied_count + 9'd1;
      end
      if (!last_beat) begin
        scan_addr <= next_addr;
        scan_data <= point_at(board, next_addr);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memory_read_scan.sv
// ============================================================================
// Module   : tb_memory_read_scan
// Brief    : Randomized self-checking bench for memory_read_scan against a
//            behavioural model of the read/scan rules.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_memory_read_scan;

  localparam int M_IDLE = 0;
  localparam int M_READ = 1;
  localparam int M_SCAN = 2;
  localparam int M_DONE = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [511:0] board = '0;
  logic         rd_req = 1'b0;
  logic [7:0]   rd_addr = 8'h00;
  logic         scan_start = 1'b0;
  logic         scan_abort = 1'b0;
  logic         scan_ready = 1'b0;
  logic         rd_valid;
  logic [1:0]   rd_data;
  logic         scan_valid;
  logic [7:0]   scan_addr;
  logic [1:0]   scan_data;
  logic         scan_done;
  logic [8:0]   occupied_count;
  logic         busy;

  int vectors = 0;
  int errors  = 0;
  bit cmp_en  = 1'b0;

  int       m_mode  = M_IDLE;
  logic [1:0] m_rdd = 2'b00;
  logic [1:0] m_sdata = 2'b00;
  int       m_addr  = 0;
  int       m_count = 0;

  int sb_next     = 0;
  int beats       = 0;
  int last_beats  = 0;
  int done_pulses = 0;

  memory_read_scan dut (
    .clock          (clock),
    .reset          (reset),
    .board          (board),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .scan_start     (scan_start),
    .scan_abort     (scan_abort),
    .scan_valid     (scan_valid),
    .scan_ready     (scan_ready),
    .scan_addr      (scan_addr),
    .scan_data      (scan_data),
    .scan_done      (scan_done),
    .occupied_count (occupied_count),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [1:0] pt(input logic [511:0] b, input int a);
    int x;
    int y;
    x = a / 16;
    y = a % 16;
    return b[32*x + 2*y +: 2];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: one step of the read/scan rules per rising edge.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode  <= M_IDLE;
      m_rdd   <= 2'b00;
      m_sdata <= 2'b00;
      m_addr  <= 0;
      m_count <= 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (rd_req) begin
            m_mode <= M_READ;
            m_rdd  <= pt(board, int'(rd_addr));
          end else if (scan_start) begin
            m_mode  <= M_SCAN;
            m_addr  <= 0;
            m_sdata <= pt(board, 0);
            m_count <= 0;
          end
        end
        M_SCAN: begin
          if (scan_ready) begin
            if (m_sdata != 2'b00) m_count <= m_count + 1;
            if (m_addr == 255) begin
              m_mode <= M_DONE;
            end else begin
              m_addr  <= m_addr + 1;
              m_sdata <= pt(board, m_addr + 1);
            end
          end
          if (scan_abort) m_mode <= M_IDLE;
        end
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (cmp_en && !reset) begin
        check("rd_valid", rd_valid, (m_mode == M_READ));
        check("rd_data", rd_data, m_rdd);
        check("scan_valid", scan_valid, (m_mode == M_SCAN));
        check("scan_addr", scan_addr, m_addr);
        check("scan_data", scan_data, m_sdata);
        check("scan_done", scan_done, (m_mode == M_DONE));
        check("busy", busy, (m_mode == M_SCAN || m_mode == M_DONE));
        check("occupied_count", occupied_count, m_count);
        if (scan_done) done_pulses++;
        if (scan_valid && scan_ready) begin
          check("scan_order", scan_addr, sb_next);
          sb_next++;
          beats++;
        end
        if (!busy) begin
          if (beats != 0) last_beats = beats;
          beats   = 0;
          sb_next = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic rand_board();
    for (int i = 0; i < 16; i++) board[32*i +: 32] = $urandom;
  endtask

  task automatic set_pt(input int a, input logic [1:0] v);
    board[2*a +: 2] = v;
  endtask

  task automatic start_scan();
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!scan_done && n < budget) begin
      step();
      n++;
    end
    if (!scan_done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_addr(input logic [7:0] a, input int budget);
    int n;
    n = 0;
    while (!(scan_valid && scan_addr == a) && n < budget) begin
      step();
      n++;
    end
    if (!(scan_valid && scan_addr == a)) check("addr_timeout", {24'd0, scan_addr}, {24'd0, a});
  endtask

  initial begin
    int d0;
    int n;

    // Reset state
    #12;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_scan_valid", scan_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_scan_addr", scan_addr, 0);
    check("rst_count", occupied_count, 0);
    @(posedge clock);
    #2;
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Single read of (3,5)=10
    step();
    set_pt(16*3 + 5, 2'b10);
    rd_addr = 8'h35;
    rd_req  = 1'b1;
    step();
    rd_req = 1'b0;
    check("read35_valid", rd_valid, 1);
    check("read35_data", rd_data, 2'b10);
    step();
    check("read35_valid_drop", rd_valid, 0);
    check("read35_data_hold", rd_data, 2'b10);

    // Full scan, ready held, three occupied points
    board = '0;
    set_pt(8'h00, 2'b01);
    set_pt(8'hFF, 2'b10);
    set_pt(8'h78, 2'b01);
    scan_ready = 1'b1;
    d0 = done_pulses;
    start_scan();
    wait_done(400);
    step();
    step();
    check("full_beats", last_beats, 256);
    check("full_done_pulses", done_pulses - d0, 1);
    check("full_count", occupied_count, 3);

    // Randomized stalls with the board changing underneath
    rand_board();
    scan_ready = 1'b0;
    start_scan();
    n = 0;
    while (!scan_done && n < 3000) begin
      scan_ready = 1'($urandom % 2);
      if (!scan_ready) rand_board();
      step();
      n++;
    end
    if (!scan_done) check("stall_done_timeout", 32'd0, 32'd1);
    step();
    step();
    check("stall_beats", last_beats, 256);

    // Read and scan requested together: the read wins
    scan_ready = 1'b1;
    rd_addr    = 8'h78;
    rd_req     = 1'b1;
    scan_start = 1'b1;
    step();
    rd_req     = 1'b0;
    scan_start = 1'b0;
    check("both_rd_valid", rd_valid, 1);
    check("both_busy", busy, 0);
    step();
    check("both_busy_after", busy, 0);

    // Read request during a scan is dropped
    start_scan();
    rd_addr = 8'h11;
    rd_req  = 1'b1;
    step();
    rd_req = 1'b0;
    check("scan_rd_ignored", rd_valid, 0);
    wait_done(400);
    step();

    // Abort at beat 0x40; 0x40 transfers with the abort
    board = '0;
    for (int a = 0; a <= 8'h40; a += 16) set_pt(a, 2'b01);
    d0 = done_pulses;
    start_scan();
    wait_addr(8'h40, 300);
    scan_abort = 1'b1;
    step();
    scan_abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", scan_valid, 0);
    check("abort_count", occupied_count, 5);
    step();
    step();
    check("abort_no_done", done_pulses - d0, 0);
    check("abort_count_hold", occupied_count, 5);
    start_scan();
    check("restart_addr", scan_addr, 0);
    check("restart_count", occupied_count, 0);
    check("restart_valid", scan_valid, 1);
    wait_done(400);
    step();

    // Asynchronous reset at beat 0x80
    rand_board();
    d0 = done_pulses;
    start_scan();
    wait_addr(8'h80, 300);
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_scan_valid", scan_valid, 0);
    check("arst_scan_done", scan_done, 0);
    check("arst_rd_valid", rd_valid, 0);
    check("arst_scan_addr", scan_addr, 0);
    check("arst_scan_data", scan_data, 0);
    check("arst_rd_data", rd_data, 0);
    check("arst_count", occupied_count, 0);
    #1;
    reset = 1'b0;
    rd_addr = 8'h80;
    rd_req  = 1'b1;
    step();
    rd_req = 1'b0;
    check("arst_read_valid", rd_valid, 1);
    check("arst_read_data", rd_data, pt(board, 8'h80));
    step();
    step();
    check("arst_no_done", done_pulses - d0, 0);

    // Random reads, sometimes colliding with scan_start
    for (int i = 0; i < 16; i++) begin
      rand_board();
      rd_addr    = 8'($urandom);
      rd_req     = 1'b1;
      scan_start = 1'($urandom % 2);
      step();
      rd_req     = 1'b0;
      scan_start = 1'b0;
      step();
    end

    scan_ready = 1'b0;
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
